uart_alu_interface: RTL and testbench

User-side endpoint of the FIFO-buffered `uart` block, facing its receive and transmit FIFOs. It pops a three-byte command from the RX FIFO: operand A, then operand B, then an opcode. It evaluates the command in an 8-bit ALU and pushes the one-byte result into the TX FIFO. It sits between the `uart` instance and the board I/O in the top level, driving `rd_uart`/`wr_uart` and consuming `rx_empty`/`r_data`/`tx_full`.

---
 rtl/uart_alu_pkg.sv | 25 ++
 rtl/uart_alu_interface_alu.sv | 34 +++
 rtl/uart_alu_interface.sv | 114 +++++++++++
 tb/tb_uart_alu_interface.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-facing ALU endpoint: opcodes, FSM encoding, default data width.
// No logic; imported by the ALU and the interface FSM.
// Backpressure not applicable.
package uart_alu_pkg;

    localparam int NB_DATA_DEF = 8;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4
    } state_t;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Combinational 8-op ALU; unknown opcodes yield zero, arithmetic wraps.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module alu
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_DATA-1:0] op,
    output logic [NB_DATA-1:0] res
);

    // Shift amounts use only the low three bits of B.
    logic [2:0] shamt;
    assign shamt = b[2:0];

    always_comb begin
        res = '0;
        case (op)
            NB_DATA'(OP_ADD): res = a + b;
            NB_DATA'(OP_SUB): res = a - b;
            NB_DATA'(OP_AND): res = a & b;
            NB_DATA'(OP_OR):  res = a | b;
            NB_DATA'(OP_XOR): res = a ^ b;
            NB_DATA'(OP_NOR): res = ~(a | b);
            NB_DATA'(OP_SRA): res = $unsigned($signed(a) >>> shamt);
            NB_DATA'(OP_SRL): res = a >> shamt;
            default:          res = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Pops A, B, opcode from the UART RX FIFO, evaluates them, pushes the result to the TX FIFO.
// Latency: result pushed two cycles after the opcode pop; minimum command period five cycles.
// Backpressure: holds in SEND while tx_full; optional inter-byte timeout under UART_IF_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int TO_BIT      = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [NB_DATA-1:0] r_data,
    output logic               rd_uart,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [NB_DATA-1:0] w_data,
    output logic [NB_DATA-1:0] led,
    output logic               timeout_tick
);

    state_t             state, state_next;
    logic [NB_DATA-1:0] a_reg, b_reg, op_reg;
    logic [NB_DATA-1:0] alu_res;
    logic               to_hit;

`ifdef UART_IF_TIMEOUT_EN
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT_CYC - 1);

    logic [TO_BIT-1:0] to_cnt;
    logic              starving;

    assign starving = ((state == WAIT_B) || (state == WAIT_OP)) && rx_empty;
    assign to_hit   = starving && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (!starving || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    alu #(.NB_DATA(NB_DATA)) u_alu (
        .a   (a_reg),
        .b   (b_reg),
        .op  (op_reg),
        .res (alu_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // A pop always beats a timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (!rx_empty) state_next = WAIT_B;
            WAIT_B:  if (!rx_empty) state_next = WAIT_OP;
                     else if (to_hit) state_next = WAIT_A;
            WAIT_OP: if (!rx_empty) state_next = CALC;
                     else if (to_hit) state_next = WAIT_A;
            CALC:    state_next = SEND;
            SEND:    if (!tx_full) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    always_comb begin
        rd_uart      = 1'b0;
        wr_uart      = 1'b0;
        timeout_tick = 1'b0;
        case (state)
            WAIT_A:  rd_uart = reset & ~rx_empty;
            WAIT_B,
            WAIT_OP: begin
                rd_uart      = reset & ~rx_empty;
                timeout_tick = reset & to_hit;
            end
            SEND:    wr_uart = reset & ~tx_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            w_data <= '0;
            led    <= '0;
        end else begin
            if (state == WAIT_A && !rx_empty)  a_reg  <= r_data;
            if (state == WAIT_B && !rx_empty)  b_reg  <= r_data;
            if (state == WAIT_OP && !rx_empty) op_reg <= r_data;
            if (state == CALC) begin
                w_data <= alu_res;
                led    <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench: show-ahead RX FIFO model feeds command bytes, TX pushes are collected and checked.
// Expected results are hand-computed constants.
module tb_uart_alu_interface;

`ifdef UART_IF_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 50_000_000;
`endif

    logic       clk;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] led;
    logic       timeout_tick;

    int checks;
    int fails;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         wr_cyc_q[$];
    int         cyc;
    int         rd_cnt;
    int         wr_cnt;
    int         tick_cnt;
    int         overlap_cnt;

    uart_alu_interface #(.NB_DATA(8), .TIMEOUT_CYC(TO_CYC), .TO_BIT(26)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_empty     (rx_empty),
        .r_data       (r_data),
        .rd_uart      (rd_uart),
        .tx_full      (tx_full),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .led          (led),
        .timeout_tick (timeout_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // FIFO side effects land at the edge; the visible head changes at the next falling edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rd_uart && wr_uart) overlap_cnt = overlap_cnt + 1;
        if (rd_uart && rx_q.size() != 0) begin
            void'(rx_q.pop_front());
            rd_cnt = rd_cnt + 1;
        end
        if (wr_uart) begin
            tx_q.push_back(w_data);
            wr_cyc_q.push_back(cyc);
            wr_cnt = wr_cnt + 1;
        end
        if (timeout_tick) tick_cnt = tick_cnt + 1;
    end

    always @(negedge clk) refresh();

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        rx_q.push_back(d);
        refresh();
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        push(a);
        push(b);
        push(op);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] exp);
        int waited;
        waited = 0;
        while (tx_q.size() == 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (tx_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_w_data"}, {24'd0, tx_q.pop_front()}, {24'd0, exp});
            void'(wr_cyc_q.pop_front());
            check({tag, "_led"}, {24'd0, led}, {24'd0, exp});
        end
    endtask

    initial begin
        int c0;
        int rc0;
        logic [7:0] ws;
        int w1;
        int w2;

        checks = 0; fails = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0;
        tick_cnt = 0; overlap_cnt = 0;
        reset = 1'b0; tx_full = 1'b0;
        refresh();
        cycles(3);
        check("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
        check("rst_wr_uart", {31'd0, wr_uart}, 32'd0);
        check("rst_w_data", {24'd0, w_data}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        reset = 1'b1;
        cycles(2);

        // Basic ADD with exact pop/push timing.
        c0 = cyc;
        push_cmd(8'h05, 8'h03, 8'h20);
        cycles(3);
        check("add_pops", rd_cnt, 32'd3);
        cycles(3);
        check("add_push_latency", (wr_cyc_q.size() != 0) ? wr_cyc_q[0] - c0 : -1, 32'd5);
        expect_result("add", 8'h08);
        check("add_one_push", wr_cnt, 32'd1);

        // Back-to-back commands run at the minimum five-cycle period.
        push_cmd(8'h03, 8'h05, 8'h22);
        push_cmd(8'hFF, 8'h01, 8'h20);
        cycles(14);
        w1 = (wr_cyc_q.size() > 1) ? wr_cyc_q[0] : 0;
        w2 = (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : 0;
        check("b2b_period", w2 - w1, 32'd5);
        check("sub_w_data", {24'd0, (tx_q.size() > 0) ? tx_q[0] : 8'hxx}, 32'hFE);
        check("add_wrap_w_data", {24'd0, (tx_q.size() > 1) ? tx_q[1] : 8'hxx}, 32'h00);
        tx_q.delete(); wr_cyc_q.delete();

        push_cmd(8'h80, 8'h02, 8'h03); expect_result("sra", 8'hE0);
        push_cmd(8'h90, 8'h0A, 8'h03); expect_result("sra_b_low3", 8'hE4);
        push_cmd(8'h80, 8'h02, 8'h02); expect_result("srl", 8'h20);
        push_cmd(8'h0F, 8'hF0, 8'h27); expect_result("nor", 8'h00);
        push_cmd(8'h12, 8'h34, 8'h11); expect_result("unknown_op", 8'h00);
        push_cmd(8'hF0, 8'h3C, 8'h24); expect_result("and", 8'h30);
        push_cmd(8'hF0, 8'h0C, 8'h25); expect_result("or", 8'hFC);
        push_cmd(8'hFF, 8'h0F, 8'h26); expect_result("xor", 8'hF0);

        // TX stall: no push, no pop, stable w_data while tx_full.
        tx_full = 1'b1;
        push_cmd(8'h09, 8'h07, 8'h24);
        cycles(6);
        ws  = w_data;
        rc0 = rd_cnt;
        c0  = wr_cnt;
        push(8'h01);
        cycles(10);
        check("stall_no_push", wr_cnt - c0, 32'd0);
        check("stall_w_data_value", {24'd0, ws}, 32'h01);
        check("stall_w_data_stable", {24'd0, w_data}, {24'd0, ws});
        check("stall_no_pop", rd_cnt - rc0, 32'd0);
        tx_full = 1'b0;
        expect_result("stall_release", 8'h01);
        cycles(3);
        check("stall_one_push", wr_cnt - c0, 32'd1);
        push(8'h02); push(8'h20);
        expect_result("after_stall", 8'h03);

`ifdef UART_IF_TIMEOUT_EN
        // Lone A byte then idle: partial command is discarded once.
        c0 = tick_cnt;
        push(8'h07);
        cycles(110);
        check("timeout_one_tick", tick_cnt - c0, 32'd1);
        push_cmd(8'h01, 8'h02, 8'h20);
        expect_result("after_timeout", 8'h03);
`endif

        // Reset mid-command after B is popped.
        rc0 = rd_cnt;
        push(8'h40); push(8'h41);
        cycles(4);
        check("mid_pops", rd_cnt - rc0, 32'd2);
        reset = 1'b0;
        push(8'h09);
        cycles(2);
        check("mid_rst_rd_uart", {31'd0, rd_uart}, 32'd0);
        check("mid_rst_wr_uart", {31'd0, wr_uart}, 32'd0);
        check("mid_rst_tick", {31'd0, timeout_tick}, 32'd0);
        check("mid_rst_w_data", {24'd0, w_data}, 32'd0);
        check("mid_rst_led", {24'd0, led}, 32'd0);
        check("mid_rst_fifo_kept", rx_q.size(), 32'd1);
        reset = 1'b1;
        push(8'h04); push(8'h22);
        expect_result("after_reset", 8'h05);

        cycles(5);
        check("no_rd_wr_overlap", overlap_cnt, 32'd0);
        check("total_pushes_flushed", tx_q.size(), 32'd0);
`ifndef UART_IF_TIMEOUT_EN
        check("tick_tied_low", tick_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
